// File: rtl/ars_dsa_pkg.sv
// Shared types and constants for the DSA signature verifier.
package ars_dsa_pkg;

  localparam int unsigned DSA_WIDTH = 512;

  typedef enum logic [3:0] {
    IDLE, CHECK, RED_H, INV, U1, U2, EXP1, EXP2, MULV, RED_V, CMP, DONE
  } dsa_state_e;

  typedef enum logic {
    SQR, MUL
  } exp_phase_e;

endpackage

// File: rtl/ars_dsa_verify_modmul.sv
// Bit-serial MSB-first interleaved modular multiplier: result = a*b mod m.
// One load cycle followed by WIDTH shift-add steps; operands must be < m.
module ars_modmul
  import ars_dsa_pkg::*;
#(
  parameter int unsigned WIDTH = DSA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned AW = WIDTH + 2;
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] a_q, b_q, m_q;
  logic [AW-1:0]    acc_q;
  logic [CW-1:0]    cnt_q;
  logic [AW-1:0]    sum_c, sub1_c, sub2_c;

  // acc < m and a < m keep 2*acc + a below 3m, so two subtractions suffice.
  always_comb begin
    sum_c  = (acc_q << 1) + (b_q[WIDTH-1] ? AW'(a_q) : '0);
    sub1_c = (sum_c >= AW'(m_q)) ? sum_c - AW'(m_q) : sum_c;
    sub2_c = (sub1_c >= AW'(m_q)) ? sub1_c - AW'(m_q) : sub1_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      m_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      if (!busy && start) begin
        a_q   <= a;
        b_q   <= b;
        m_q   <= m;
        acc_q <= '0;
        cnt_q <= '0;
        busy  <= 1'b1;
      end else if (busy) begin
        acc_q <= sub2_c;
        b_q   <= b_q << 1;
        cnt_q <= cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          busy   <= 1'b0;
          done   <= 1'b1;
          result <= sub2_c[WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/ars_dsa_verify.sv
// Sequential DSA verifier: v = ((g^u1 * y^u2) mod p) mod q, valid = (v == r).
// Optional DSAV_RANGE_CHECK_EN rejects r/s outside [1, q-1] before any arithmetic.
module ars_dsa_verify
  import ars_dsa_pkg::*;
#(
  parameter int unsigned WIDTH = DSA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] Hm,
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] s,
  output logic             busy,
  output logic             done,
  output logic             valid
);

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned RW = WIDTH + 1;

  dsa_state_e       state_q, state_d;
  exp_phase_e       ex_phase_q, ex_phase_d;
  logic [WIDTH-1:0] p_q, q_q, g_q, y_q, h_q, r_q, s_q;
  logic [WIDTH-1:0] p_d, q_d, g_d, y_d, h_d, r_d, s_d;
  logic [WIDTH-1:0] w_q, u1_q, u2_q, a_q, b_q, ex_acc_q;
  logic [WIDTH-1:0] w_d, u1_d, u2_d, a_d, b_d, ex_acc_d;
  logic [RW-1:0]    red_rem_q, red_rem_d;
  logic [IW-1:0]    red_cnt_q, red_cnt_d, ex_idx_q, ex_idx_d;
  logic             mm_wait_q, mm_wait_d;
  logic             busy_d, done_d, valid_d;

  logic             mm_start_c, mm_busy, mm_done;
  logic [WIDTH-1:0] mm_a_c, mm_b_c, mm_m_c, mm_result;
  logic [WIDTH-1:0] ex_e_c, red_src_c;
  logic             ex_bit_c;
  logic [RW-1:0]    red_sum_c, red_next_c;

  ars_modmul #(.WIDTH(WIDTH)) u_modmul (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (mm_start_c),
    .a      (mm_a_c),
    .b      (mm_b_c),
    .m      (mm_m_c),
    .busy   (mm_busy),
    .done   (mm_done),
    .result (mm_result)
  );

  // Shared multiplier operand mux, exponent select and reduction step.
  always_comb begin
    mm_a_c = '0;
    mm_b_c = '0;
    mm_m_c = p_q;
    ex_e_c = u2_q;
    unique case (state_q)
      INV: begin
        mm_a_c = ex_acc_q;
        mm_b_c = (ex_phase_q == SQR) ? ex_acc_q : s_q;
        mm_m_c = q_q;
        ex_e_c = q_q - WIDTH'(2);
      end
      U1: begin
        mm_a_c = h_q;
        mm_b_c = w_q;
        mm_m_c = q_q;
      end
      U2: begin
        mm_a_c = r_q;
        mm_b_c = w_q;
        mm_m_c = q_q;
      end
      EXP1: begin
        mm_a_c = ex_acc_q;
        mm_b_c = (ex_phase_q == SQR) ? ex_acc_q : g_q;
        ex_e_c = u1_q;
      end
      EXP2: begin
        mm_a_c = ex_acc_q;
        mm_b_c = (ex_phase_q == SQR) ? ex_acc_q : y_q;
      end
      MULV: begin
        mm_a_c = a_q;
        mm_b_c = b_q;
      end
      default: ;
    endcase
    ex_bit_c   = ex_e_c[ex_idx_q];
    red_src_c  = (state_q == RED_V) ? b_q : h_q;
    red_sum_c  = (red_rem_q << 1) | RW'(red_src_c[WIDTH-1]);
    red_next_c = (red_sum_c >= {1'b0, q_q}) ? red_sum_c - {1'b0, q_q} : red_sum_c;
  end

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    ex_phase_d = ex_phase_q;
    p_d = p_q; q_d = q_q; g_d = g_q; y_d = y_q;
    h_d = h_q; r_d = r_q; s_d = s_q;
    w_d = w_q; u1_d = u1_q; u2_d = u2_q; a_d = a_q; b_d = b_q;
    ex_acc_d   = ex_acc_q;
    ex_idx_d   = ex_idx_q;
    red_rem_d  = red_rem_q;
    red_cnt_d  = red_cnt_q;
    mm_wait_d  = mm_wait_q;
    mm_start_c = 1'b0;
    valid_d    = valid;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          p_d = p; q_d = q; g_d = g; y_d = y;
          h_d = Hm; r_d = r; s_d = s;
          valid_d = 1'b0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        red_rem_d  = '0;
        red_cnt_d  = '0;
        ex_acc_d   = WIDTH'(1);
        ex_idx_d   = IW'(WIDTH - 1);
        ex_phase_d = SQR;
`ifdef DSAV_RANGE_CHECK_EN
        if (r_q == '0 || s_q == '0 || r_q >= q_q || s_q >= q_q) state_d = DONE;
        else state_d = RED_H;
`else
        state_d = RED_H;
`endif
      end
      RED_H, RED_V: begin
        red_rem_d = red_next_c;
        red_cnt_d = red_cnt_q + IW'(1);
        if (state_q == RED_H) h_d = h_q << 1;
        else b_d = b_q << 1;
        if (red_cnt_q == IW'(WIDTH - 1)) begin
          if (state_q == RED_H) begin
            h_d = red_next_c[WIDTH-1:0];
            state_d = INV;
          end else begin
            b_d = red_next_c[WIDTH-1:0];
            state_d = CMP;
          end
        end
      end
      INV, EXP1, EXP2: begin
        if (!mm_wait_q && !mm_busy) begin
          mm_start_c = 1'b1;
          mm_wait_d  = 1'b1;
        end else if (mm_done) begin
          mm_wait_d = 1'b0;
          ex_acc_d  = mm_result;
          if (ex_phase_q == SQR && ex_bit_c) begin
            ex_phase_d = MUL;
          end else begin
            ex_phase_d = SQR;
            ex_idx_d   = ex_idx_q - IW'(1);
            if (ex_idx_q == '0) begin
              ex_acc_d = WIDTH'(1);
              ex_idx_d = IW'(WIDTH - 1);
              unique case (state_q)
                INV:     begin w_d = mm_result; state_d = U1;   end
                EXP1:    begin a_d = mm_result; state_d = EXP2; end
                default: begin b_d = mm_result; state_d = MULV; end
              endcase
            end
          end
        end
      end
      U1, U2, MULV: begin
        if (!mm_wait_q && !mm_busy) begin
          mm_start_c = 1'b1;
          mm_wait_d  = 1'b1;
        end else if (mm_done) begin
          mm_wait_d = 1'b0;
          unique case (state_q)
            U1:      begin u1_d = mm_result; state_d = U2; end
            U2:      begin u2_d = mm_result; state_d = EXP1; end
            default: begin
              b_d       = mm_result;
              red_rem_d = '0;
              red_cnt_d = '0;
              state_d   = RED_V;
            end
          endcase
        end
      end
      CMP: begin
        valid_d = (b_q == r_q);
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ex_phase_q <= SQR;
      p_q <= '0; q_q <= '0; g_q <= '0; y_q <= '0;
      h_q <= '0; r_q <= '0; s_q <= '0;
      w_q <= '0; u1_q <= '0; u2_q <= '0; a_q <= '0; b_q <= '0;
      ex_acc_q  <= '0;
      ex_idx_q  <= '0;
      red_rem_q <= '0;
      red_cnt_q <= '0;
      mm_wait_q <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      valid     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ex_phase_q <= ex_phase_d;
      p_q <= p_d; q_q <= q_d; g_q <= g_d; y_q <= y_d;
      h_q <= h_d; r_q <= r_d; s_q <= s_d;
      w_q <= w_d; u1_q <= u1_d; u2_q <= u2_d; a_q <= a_d; b_q <= b_d;
      ex_acc_q  <= ex_acc_d;
      ex_idx_q  <= ex_idx_d;
      red_rem_q <= red_rem_d;
      red_cnt_q <= red_cnt_d;
      mm_wait_q <= mm_wait_d;
      busy      <= busy_d;
      done      <= done_d;
      valid     <= valid_d;
    end
  end

endmodule

// File: tb/tb_ars_dsa_verify.sv
// Self-checking bench for ars_dsa_verify at WIDTH=16 (p=23, q=11, g=2, x=5).
module tb_ars_dsa_verify;

  localparam int unsigned W = 16;
  localparam int LAT_MAX = (4 * W + 3) * (W + 1) + 2 * W + 8;

  typedef struct {
    logic [W-1:0] p, q, g, y, hm, r, s;
    logic         ev;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] p = '0, q = '0, g = '0, y = '0, hm = '0, r = '0, s = '0;
  logic         busy, done, valid;

  int   checks = 0;
  int   errors = 0;
  logic exp_q[$];
  vec_t tbl[7];

  always #5 clk = ~clk;

  ars_dsa_verify #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .p     (p),
    .q     (q),
    .g     (g),
    .y     (y),
    .Hm    (hm),
    .r     (r),
    .s     (s),
    .busy  (busy),
    .done  (done),
    .valid (valid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic drive(input vec_t v);
    p = v.p; q = v.q; g = v.g; y = v.y; hm = v.hm; r = v.r; s = v.s;
  endtask

  task automatic launch(input vec_t v);
    @(negedge clk);
    drive(v);
    start = 1'b1;
    exp_q.push_back(v.ev);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  // Waits for done, pops the scoreboard, then checks the one-cycle pulse and held result.
  task automatic wait_done(input string name, output int cyc);
    logic e;
    cyc = 1;
    while (!done && cyc < LAT_MAX) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
    if (!done) begin
      chk({name, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({name, "_valid"}, 32'(valid), 32'(e));
      @(posedge clk);
      #1;
      chk({name, "_done_pulse"}, 32'(done), 32'd0);
      chk({name, "_busy_low"}, 32'(busy), 32'd0);
      chk({name, "_valid_held"}, 32'(valid), 32'(e));
    end
  endtask

  initial begin
    int cyc;
    int k;
    int ndone;
    vec_t v;

    tbl[0] = '{16'd23, 16'd11, 16'd2, 16'd9, 16'd10,     16'd2, 16'd6, 1'b1};
    tbl[1] = '{16'd23, 16'd11, 16'd2, 16'd9, 16'd11,     16'd2, 16'd6, 1'b0};
    tbl[2] = '{16'd23, 16'd11, 16'd2, 16'd9, 16'd3,      16'd8, 16'd7, 1'b1};
    tbl[3] = '{16'd23, 16'd11, 16'd2, 16'd9, 16'd25,     16'd8, 16'd7, 1'b1};
    tbl[4] = '{16'd23, 16'd11, 16'd2, 16'd9, 16'hFFFF,   16'd2, 16'd1, 1'b1};
    tbl[5] = '{16'd23, 16'd11, 16'd2, 16'd9, 16'd10,     16'd2, 16'd7, 1'b0};
`ifdef DSAV_RANGE_CHECK_EN
    tbl[6] = '{16'd23, 16'd11, 16'd2, 16'd9, 16'd10,     16'd1, 16'd0, 1'b0};
`else
    tbl[6] = '{16'd23, 16'd11, 16'd2, 16'd9, 16'd10,     16'd1, 16'd0, 1'b1};
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors, back to back
    for (int i = 0; i < 7; i++) begin
      launch(tbl[i]);
      wait_done($sformatf("vec%0d", i), cyc);
    end

    // Internal values for the reference vector and its Hm=11 variant
    launch(tbl[0]);
    wait_done("ref", cyc);
    chk("ref_latency", 32'(cyc <= LAT_MAX), 32'd1);
    chk("ref_w", 32'(dut.w_q), 32'd2);
    chk("ref_u1", 32'(dut.u1_q), 32'd9);
    chk("ref_u2", 32'(dut.u2_q), 32'd4);
    chk("ref_v", 32'(dut.b_q), 32'd2);
    launch(tbl[1]);
    wait_done("hm11", cyc);
    chk("hm11_u1", 32'(dut.u1_q), 32'd0);
    chk("hm11_v", 32'(dut.b_q), 32'd6);

`ifdef DSAV_RANGE_CHECK_EN
    launch(tbl[6]);
    wait_done("fast_s0", cyc);
    chk("fast_s0_latency", 32'(cyc <= 3), 32'd1);
    v = tbl[0]; v.r = 16'd11; v.ev = 1'b0;
    launch(v);
    wait_done("fast_r_eq_q", cyc);
    chk("fast_r_eq_q_latency", 32'(cyc <= 3), 32'd1);
    v = tbl[0]; v.r = 16'd0; v.ev = 1'b0;
    launch(v);
    wait_done("fast_r0", cyc);
    chk("fast_r0_latency", 32'(cyc <= 3), 32'd1);
`endif

    // Asynchronous reset in the middle of EXP1
    launch(tbl[0]);
    k = 0;
    while (dut.state_q != ars_dsa_pkg::EXP1 && k < LAT_MAX) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("reach_exp1", 32'(dut.state_q == ars_dsa_pkg::EXP1), 32'd1);
    chk("busy_in_exp1", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_valid", 32'(valid), 32'd0);
    chk("abort_p_cleared", 32'(dut.p_q), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    launch(tbl[0]);
    wait_done("after_abort", cyc);

    // start held high through a full run, including the DONE cycle
    @(negedge clk);
    drive(tbl[0]);
    start = 1'b1;
    exp_q.push_back(1'b1);
    ndone = 0;
    cyc = 0;
    while (!done && cyc < LAT_MAX) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (done) ndone++;
    chk("held_valid", 32'(valid), 32'(exp_q.pop_front()));
    @(posedge clk);
    #1;
    start = 1'b0;
    if (done) ndone++;
    chk("held_start_in_done_ignored", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    if (done) ndone++;
    chk("held_idle", 32'(busy), 32'd0);
    chk("held_one_done", 32'(ndone), 32'd1);

    // start pulsed while busy with different operands
    launch(tbl[0]);
    repeat (40) @(posedge clk);
    @(negedge clk);
    v = tbl[5];
    v.hm = 16'd11;
    drive(v);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_pulse", cyc);
    chk("busy_pulse_s_kept", 32'(dut.s_q), 32'd6);
    chk("busy_pulse_v", 32'(dut.b_q), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
